// File: rtl/komandara_arb_pkg.sv
// Shared types and helpers for the komandara stream arbiter.
package komandara_arb_pkg;

  // Lock FSM states; ARB_LOCKED exists only when burst lock is built in.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Smallest requester count that makes arbitration meaningful.
  localparam int ARB_MIN_REQ = 2;

  // Width of a requester index.
  function automatic int arb_id_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/komandara_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module komandara_rr_pick
  import komandara_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_WIDTH = arb_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_idx,
  output logic                any_valid
);

  logic [ID_WIDTH-1:0] idx;

  // Walk the requesters in priority order starting at ptr; the first hit wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
      if (!any_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/komandara_stream_arbiter.sv
// Round-robin N:1 valid/ready stream arbiter with a registered single-entry
// output stage. Optional burst lock is compiled in with the macro
// KOMANDARA_ARB_BURST_LOCK_EN: once a requester starts a multi-beat burst the
// grant stays on it until its last beat is accepted.
//
// Handshake: a beat moves on a side when valid and ready are both high at the
// rising clock edge. Upstream, s_ready_o is one-hot or zero and is only raised
// for the current winner while the output stage is free (empty or draining).
// Downstream, m_* stays stable while m_valid_o is high and m_ready_i is low.
module komandara_stream_arbiter
  import komandara_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_WIDTH  = arb_id_width(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  s_data_i,
  input  logic [NUM_REQ-1:0]                  s_valid_i,
  input  logic [NUM_REQ-1:0]                  s_last_i,
  output logic [NUM_REQ-1:0]                  s_ready_o,
  output logic [DATA_WIDTH-1:0]               m_data_o,
  output logic [ID_WIDTH-1:0]                 m_id_o,
  output logic                                m_last_o,
  output logic                                m_valid_o,
  input  logic                                m_ready_i
);

  if (NUM_REQ < ARB_MIN_REQ) begin : g_bad_num_req
    $error("komandara_stream_arbiter: NUM_REQ must be at least 2");
  end

  logic                load_en;
  logic                accept;
  logic                adv_ptr;
  logic [ID_WIDTH-1:0] ptr_q;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  gnt_vec;
  logic [ID_WIDTH-1:0] win_idx;
  logic                win_valid;

  komandara_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (s_valid_i),
    .ptr       (ptr_q),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .any_valid (pick_any)
  );

  // Output stage can take a beat when empty or when its beat leaves this cycle.
  assign load_en = ~m_valid_o | m_ready_i;
  assign accept  = load_en & win_valid;

`ifdef KOMANDARA_ARB_BURST_LOCK_EN
  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] lock_q, lock_d;

  // Winner: the round-robin pick in IDLE, the locked requester in LOCKED.
  always_comb begin
    win_idx   = pick_idx;
    win_valid = pick_any;
    gnt_vec   = pick_gnt;
    if (state_q == ARB_LOCKED) begin
      win_idx          = lock_q;
      win_valid        = s_valid_i[lock_q];
      gnt_vec          = '0;
      gnt_vec[lock_q]  = s_valid_i[lock_q];
    end
  end

  // Lock FSM: a non-last beat opens a burst, the last beat closes it.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    adv_ptr = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          if (s_last_i[win_idx]) begin
            adv_ptr = 1'b1;
          end else begin
            state_d = ARB_LOCKED;
            lock_d  = win_idx;
          end
        end
      end
      ARB_LOCKED: begin
        if (accept && s_last_i[win_idx]) begin
          state_d = ARB_IDLE;
          adv_ptr = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end
`else
  // Without burst lock every beat is arbitrated and every accept moves the pointer.
  assign win_idx   = pick_idx;
  assign win_valid = pick_any;
  assign gnt_vec   = pick_gnt;
  assign adv_ptr   = accept;
`endif

  // Ready is forced low during reset so upstream never sees a handshake then.
  assign s_ready_o = (rst_ni && load_en) ? gnt_vec : '0;

  // Round-robin pointer: the requester after the last winner gets top priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (adv_ptr) begin
      ptr_q <= (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Output register: load the winner's beat, drain, or hold under stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_id_o    <= '0;
      m_last_o  <= 1'b0;
    end else if (load_en) begin
      m_valid_o <= accept;
      if (accept) begin
        m_data_o <= s_data_i[win_idx];
        m_id_o   <= win_idx;
        m_last_o <= s_last_i[win_idx];
      end
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(s_ready_o));

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_valid_o && !m_ready_i) |=>
      (m_valid_o && $stable(m_data_o) && $stable(m_id_o) && $stable(m_last_o)));
`endif

endmodule

// File: tb/tb_komandara_stream_arbiter.sv
// Bench for komandara_stream_arbiter: directed scenarios plus a long random
// run against a queue-based reference model. Follows the lock behaviour
// selected by KOMANDARA_ARB_BURST_LOCK_EN.
module tb_komandara_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int BW = IW + 1 + DW;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N-1:0][DW-1:0] s_data_i = '0;
  logic [N-1:0]         s_valid_i = '0;
  logic [N-1:0]         s_last_i = '0;
  logic [N-1:0]         s_ready_o;
  logic [DW-1:0]        m_data_o;
  logic [IW-1:0]        m_id_o;
  logic                 m_last_o;
  logic                 m_valid_o;
  logic                 m_ready_i = 1'b0;

  komandara_stream_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_last_i  (s_last_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_id_o    (m_id_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
  );

  // Clock and counters
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: beats accepted but not yet delivered, plus the fairness state.
  logic [BW-1:0] exp_q[$];
  int            ptr_m;
  bit            locked_m;
  logic [IW-1:0] lock_m;

  // Observations from the latest step, for directed constant checks.
  logic [N-1:0]  seen_rdy;
  logic          seen_valid;
  logic [DW-1:0] seen_data;
  logic [IW-1:0] seen_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ptr_m    = 0;
    locked_m = 1'b0;
    lock_m   = '0;
  endtask

  // Hold reset for two cycles, check reset values, release at a falling edge.
  task automatic apply_reset();
    rst_ni    = 1'b0;
    s_valid_i = '0;
    s_data_i  = '0;
    s_last_i  = '0;
    m_ready_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_m_id", m_id_o, 0);
    check("rst_m_last", m_last_o, 0);
    check("rst_s_ready", s_ready_o, 0);
    rst_ni = 1'b1;
  endtask

  // One cycle: drive inputs just after a falling edge, compare against the
  // model, advance the model, and wait for the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] d,
                      input logic [N-1:0] l, input logic rdy);
    bit            exp_valid, load, found, acc;
    logic [IW-1:0] wi, ix;
    logic [N-1:0]  er;
    s_valid_i = v;
    s_data_i  = d;
    s_last_i  = l;
    m_ready_i = rdy;
    #1;
    seen_rdy   = s_ready_o;
    seen_valid = m_valid_o;
    seen_data  = m_data_o;
    seen_id    = m_id_o;

    exp_valid = (exp_q.size() != 0);
    check("m_valid", m_valid_o, exp_valid);
    load  = !exp_valid || rdy;
    found = 1'b0;
    wi    = '0;
    if (locked_m) begin
      found = v[lock_m];
      wi    = lock_m;
    end else begin
      for (int k = 0; k < N; k++) begin
        ix = IW'((ptr_m + k) % N);
        if (!found && v[ix]) begin
          found = 1'b1;
          wi    = ix;
        end
      end
    end
    acc = load && found;
    er  = '0;
    if (acc) er[wi] = 1'b1;
    check("s_ready", s_ready_o, er);

    if (exp_valid) begin
      check("m_beat", {m_id_o, m_last_o, m_data_o}, exp_q[0]);
      if (rdy) void'(exp_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back({wi, l[wi], d[wi]});
`ifdef KOMANDARA_ARB_BURST_LOCK_EN
      if (!locked_m && !l[wi]) begin
        locked_m = 1'b1;
        lock_m   = wi;
      end else if (l[wi]) begin
        locked_m = 1'b0;
        ptr_m    = (int'(wi) + 1) % N;
      end
`else
      ptr_m = (int'(wi) + 1) % N;
`endif
    end
    @(negedge clk_i);
  endtask

  logic [N-1:0][DW-1:0] d;
  logic [N-1:0]         t1_seq[5];
  logic [N-1:0]         t4_v[5];
  logic [N-1:0]         t4_l[5];
  logic [N-1:0]         t4_exp[5];

  initial begin
    for (int i = 0; i < N; i++) d[i] = 32'hD0 + DW'(i);
    t1_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Test 1: all requesters valid, downstream always ready.
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      step(4'hF, d, 4'hF, 1'b1);
      check("t1_grant", seen_rdy, t1_seq[j]);
      if (j > 0) begin
        check("t1_valid", seen_valid, 1);
        check("t1_id", seen_id, (j - 1) % N);
      end
    end

    // Test 2: lone requester 2, one-cycle latency then drain.
    apply_reset();
    d[2] = 32'hA5;
    step(4'b0100, d, 4'b0100, 1'b1);
    check("t2_grant", seen_rdy, 4'b0100);
    step(4'b0000, d, 4'b0000, 1'b1);
    check("t2_valid", seen_valid, 1);
    check("t2_data", seen_data, 32'hA5);
    check("t2_id", seen_id, 2);
    step(4'b0000, d, 4'b0000, 1'b1);
    check("t2_drain", seen_valid, 0);

    // Test 3: stall holds the beat; waiting requester wins when ready returns.
    apply_reset();
    d[1] = 32'h11;
    d[3] = 32'h33;
    step(4'b0010, d, 4'b1010, 1'b1);
    check("t3_grant1", seen_rdy, 4'b0010);
    for (int j = 0; j < 3; j++) begin
      step(4'b1000, d, 4'b1010, 1'b0);
      check("t3_stall_rdy", seen_rdy, 4'b0000);
      check("t3_stall_data", seen_data, 32'h11);
    end
    step(4'b1000, d, 4'b1010, 1'b1);
    check("t3_grant3", seen_rdy, 4'b1000);

    // Test 4/5: req0 three-beat burst with a gap, req1 competing.
    apply_reset();
    d[0] = 32'hB0;
    d[1] = 32'hB1;
    t4_v = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0010};
    t4_l = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0010};
`ifdef KOMANDARA_ARB_BURST_LOCK_EN
    t4_exp = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
`else
    t4_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0010};
`endif
    for (int j = 0; j < 5; j++) begin
      step(t4_v[j], d, t4_l[j], 1'b1);
      check("t4_grant", seen_rdy, t4_exp[j]);
    end

    // Test 6: reset while a beat is held in the output stage.
    apply_reset();
    step(4'hF, d, 4'h0, 1'b0);
    check("t6_grant", seen_rdy, 4'b0001);
    s_valid_i = 4'hF;
    m_ready_i = 1'b0;
    rst_ni    = 1'b0;
    #1;
    check("t6_rst_valid", m_valid_o, 0);
    check("t6_rst_data", m_data_o, 0);
    check("t6_rst_id", m_id_o, 0);
    check("t6_rst_last", m_last_o, 0);
    check("t6_rst_ready", s_ready_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(4'hF, d, 4'hF, 1'b1);
    check("t6_first_grant", seen_rdy, 4'b0001);

    // Random traffic against the model.
    apply_reset();
    for (int j = 0; j < 3000; j++) begin
      logic [N-1:0][DW-1:0] rd;
      for (int i = 0; i < N; i++) rd[i] = $urandom;
      step(N'($urandom_range(0, 15)), rd, N'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
